// File: rtl/decode_execute_pkg.sv
// Shared types, default widths and the signature step function for the decode/execute sweeper.
package decode_execute_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_SEL_W  = 3;
    localparam int DEF_SIG_W  = 16;

    // Rotate-left by one over the low w bits, then xor in the zero-extended result.
    // Operands wider than w are masked so callers may pass any zero-extended value.
    function automatic logic [63:0] sig_step(input logic [63:0] sig,
                                             input logic [63:0] rd_ext,
                                             input int unsigned w);
        logic [63:0] mask;
        logic [63:0] cur;
        logic [63:0] rot;
        mask = (w >= 32'd64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        cur  = sig & mask;
        rot  = ((cur << 1) | (cur >> (w - 32'd1))) & mask;
        return rot ^ (rd_ext & mask);
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// Operand-pair counter for the sweeper: clear, count enable and terminal-count flag.
module sweep_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = &cnt_q;

endmodule

// File: rtl/decode_execute_sweeper.sv
// Exhaustive operand sweeper and signature collector for the decode/execute unit.
// Optional zero-result counter enabled by defining SWEEPER_ZERO_CNT_EN.
module decode_execute_sweeper
    import decode_execute_pkg::*;
#(
    parameter int               DATA_W   = DEF_DATA_W,
    parameter int               SEL_W    = DEF_SEL_W,
    parameter int               SIG_W    = DEF_SIG_W,
    parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              hold,
    input  logic [DATA_W-1:0] rd_in,
    output logic [DATA_W-1:0] rs,
    output logic [DATA_W-1:0] rt,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature
`ifdef SWEEPER_ZERO_CNT_EN
    ,
    output logic [2*DATA_W:0] zero_cnt
`endif
);

    localparam int CNT_W = 2 * DATA_W;

    sweep_state_t     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] sig_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             cnt_clr;
    logic             cnt_en;
    logic             accept;

    sweep_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    always_comb begin
        sig_next = SIG_W'(sig_step(64'(sig_q), 64'(rd_in), SIG_W));
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        sig_d   = sig_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    sel_d   = sel_in;
                    sig_d   = SIG_SEED;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                // A held cycle freezes the counter and the signature; rd_in is not sampled.
                if (!hold) begin
                    cnt_en = 1'b1;
                    sig_d  = sig_next;
                    if (cnt_tc) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            sig_q   <= SIG_SEED;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            sig_q   <= sig_d;
        end
    end

`ifdef SWEEPER_ZERO_CNT_EN
    logic [2*DATA_W:0] zc_q, zc_d;

    always_comb begin
        zc_d = zc_q;
        if (accept) begin
            zc_d = '0;
        end else if (cnt_en && (rd_in == '0)) begin
            zc_d = zc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zc_q <= '0;
        end else begin
            zc_q <= zc_d;
        end
    end

    assign zero_cnt = zc_q;
`endif

    assign rs        = cnt[CNT_W-1:DATA_W];
    assign rt        = cnt[DATA_W-1:0];
    assign sel       = sel_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign signature = sig_q;

endmodule

// File: doc/decode_execute_sweeper.md
# decode_execute_sweeper

Self-running stimulus source and result collector for the `Decode_And_Execute` datapath. On `start` it latches an opcode, then walks all 256 `{rs, rt}` operand pairs, one pair per cycle, with `rt` as the inner loop. It samples the unit's combinational `rd` result each cycle and folds it into a rotating signature. It gives the lab's exhaustive sweep a synthesizable form that produces a single pass/fail value per opcode.

## Interface
Parameters:
- `DATA_W`, 4: operand and result width; the sweep length is 2^(2·DATA_W).
- `SEL_W`, 3: opcode width.
- `SIG_W`, 16: signature width; must be ≥ `DATA_W`.
- `SIG_SEED`, 16'h0000: signature value loaded on `start`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `sel_in` in `SEL_W`: opcode; latched on accepted `start`.
- `hold` in 1: stall; freezes the sweep while high.
- `rd_in` in `DATA_W`: result returned from the execute unit (combinational from `rs`/`rt`/`sel`).
- `rs` out `DATA_W`: operand A, registered.
- `rt` out `DATA_W`: operand B, registered.
- `sel` out `SEL_W`: latched opcode, registered.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when the sweep completes.
- `signature` out `SIG_W`: accumulated result signature; valid when `done` is high, and held until the next accepted `start`.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE; `rs`, `rt`, `sel` = 0; `busy` = 0; `done` = 0; `signature` = `SIG_SEED`.
- IDLE transition: in IDLE with `start` = 1, the next state is RUN. `sel` ← `sel_in`, `rs` ← 0, `rt` ← 0, `signature` ← `SIG_SEED`.
- RUN cycle with `hold` = 0:
  - `signature` ← rotl(`signature`, 1) ^ zero-extended `rd_in`.
  - `{rs, rt}` increments by 1 (`rt` is the LSBs).
  - If `{rs, rt}` was all-ones, the operands wrap to 0 and the next state is DONE.
- RUN cycle with `hold` = 1: all registers keep their values and `rd_in` is ignored.
- DONE: `done` = 1 for exactly one cycle, `busy` = 0, then the next state is IDLE. `start` is ignored in DONE.
- Ignored inputs:
  - `start` in RUN or DONE is ignored; there is no restart.
  - `sel_in` changes outside an accepted `start` have no effect.
- `rst` in any state returns to the reset values on the next edge, including in the middle of a sweep.
- Arithmetic: the operand counter has width 2·`DATA_W` and wraps modulo 2^(2·`DATA_W`). The rotate is a pure rotation over `SIG_W` bits.

## Timing
- Accepted `start` at edge E0: `busy` is high from E0 through the sweep, and the first pair (0, 0) is visible after E0.
- Pair k is presented during RUN cycle k, and `rd_in` for that pair is sampled at the end of the same cycle. The execute unit therefore needs zero cycles of latency, with `rd_in` settled within one cycle.
- With no `hold`:
  - `busy` stays high for 256 cycles (for `DATA_W` = 4).
  - `done` is high in cycle 257 after E0.
  - A new `start` is accepted earliest in cycle 258.
- Each held cycle extends the sweep by exactly one cycle.

## Configuration
- `SWEEPER_ZERO_CNT_EN` defined:
  - Adds output `zero_cnt`, width 2·`DATA_W`+1.
  - `zero_cnt` clears on `rst` and on accepted `start`.
  - It increments on each non-held RUN cycle where `rd_in` == 0.
  - It is held after DONE, with the same validity rules as `signature`.
- Not defined: no `zero_cnt` port and no counter logic.

## Structure
- Package `decode_execute_pkg`:
  - State enum `sweep_state_t` (IDLE, RUN, DONE).
  - Default `DATA_W`, `SEL_W`, `SIG_W` constants.
  - A `sig_step` function implementing the rotate-xor, so the bench model shares it.
- Sub-module `sweep_counter`: 2·`DATA_W`-bit counter with clear, enable, and a terminal-count flag. The FSM stays in the top module.

## Test plan
- Reset then idle; `rd_in` tied to 0 → after reset, all outputs are at their reset values, and `busy`/`done` stay 0 with no `start`.
- Constant `rd_in` = 4'h0, `SIG_SEED` = 16'hA5A5, `start` with `sel_in` = 3'b110:
  - `sel` = 3'b110 throughout.
  - 256 busy cycles, then `done` = 1 for one cycle.
  - `signature` = 16'hA5A5; with the macro defined, `zero_cnt` = 256.
- Constant `rd_in` = 4'h1, seed 0 → `signature` = 16'h0000 at `done`, and `{rs, rt}` observed 0x00…0xFF in order with no repeats or gaps.
- `hold` high for 10 cycles at pair 0x7F → `rs`/`rt` stay at 7/F for 10 cycles, and `done` arrives 10 cycles later than the unheld run.
- `rst` asserted at pair 0x40, followed by a new `start` → the outputs return to their reset values, and the new sweep restarts at pair 0x00 with `signature` = `SIG_SEED`.
- `start` pulsed during RUN and DONE, with `sel_in` toggled → no effect on `sel`, the counter, or the `done` timing.
